// File: rtl/pico_pkg.sv
// Shared pico definitions: next-PC mode encoding and default widths
// used by the program-counter blocks.
package pico;

  localparam int PICO_A     = 8;
  localparam int PICO_W_IMM = 8;

  typedef enum logic [1:0] {
    INCREMENT  = 2'd0,
    RELATIVE   = 2'd1,
    SUBROUTINE = 2'd2,
    RETURN     = 2'd3
  } modePC;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular storage with a saturating entry count.
// A push while full overwrites the oldest entry.
module pc_ras #(
  parameter  int A     = 8,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [A-1:0]  push_data,
  output logic [A-1:0]  top_data,
  output logic [SW-1:0] sp,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [A-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_inc;

  // wr_ptr is the next free slot; when full it is also the oldest entry
  assign rd_ptr     = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
  assign wr_ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
  assign top_data   = mem[rd_ptr];
  assign full       = (sp == SW'(DEPTH));
  assign empty      = (sp == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      sp     <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr_inc;
      if (!full) sp <= sp + SW'(1);
    end else if (pop && !empty) begin
      wr_ptr <= rd_ptr;
      sp     <= sp - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: registered PC with increment, relative branch,
// subroutine call and return through a small return-address stack.
module pc_sequencer import pico::*; #(
  parameter  int A     = PICO_A,
  parameter  int DEPTH = 4,
  parameter  int W_IMM = PICO_W_IMM,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  modePC            mode,
  input  logic             take,
  input  logic [W_IMM-1:0] imm,
  output logic [A-1:0]     pc,
  output logic [SW-1:0]    sp,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  logic [A-1:0] pc_next;
  logic [A-1:0] pc_inc;
  logic [A-1:0] imm_sext;
  logic [A-1:0] imm_zext;
  logic [A-1:0] ras_top;
  logic         push;
  logic         pop;
  logic         ovf_set;
  logic         unf_set;

  if (W_IMM >= A) begin : g_imm_trunc
    assign imm_sext = imm[A-1:0];
    assign imm_zext = imm[A-1:0];
  end else begin : g_imm_ext
    assign imm_sext = {{(A - W_IMM){imm[W_IMM-1]}}, imm};
    assign imm_zext = {{(A - W_IMM){1'b0}}, imm};
  end

  assign pc_inc = pc + A'(1);

  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (mode)
      RELATIVE:   if (take) pc_next = pc + imm_sext;
      SUBROUTINE: begin
        pc_next = imm_zext;
        push    = en;
        ovf_set = full;
      end
      RETURN: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          pc_next = ras_top;
          pop     = en;
        end
      end
      default: ;
    endcase
  end

  // Error flags are sticky: only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

  pc_ras #(
    .A     (A),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic checked
// against a queue-based model of the PC and return stack.
module tb_pc_sequencer;

  localparam int A     = 8;
  localparam int DEPTH = 4;
  localparam int W_IMM = 8;
  localparam int SW    = $clog2(DEPTH + 1);
  localparam int MASK  = (1 << A) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  pico::modePC      mode;
  logic             take;
  logic [W_IMM-1:0] imm;
  logic [A-1:0]     pc;
  logic [SW-1:0]    sp;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  int checks = 0;
  int errors = 0;

  int m_pc;
  int m_stack[$];
  bit m_ovf;
  bit m_unf;

  always #5 clk = ~clk;

  pc_sequencer #(
    .A     (A),
    .DEPTH (DEPTH),
    .W_IMM (W_IMM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .take  (take),
    .imm   (imm),
    .pc    (pc),
    .sp    (sp),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sext_imm(input int v);
    return (v >= (1 << (W_IMM - 1))) ? v - (1 << W_IMM) : v;
  endfunction

  task automatic model_edge(input bit r, input bit e, input pico::modePC m,
                            input bit t, input int i);
    if (r) begin
      m_pc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (e) begin
      case (m)
        pico::INCREMENT: m_pc = (m_pc + 1) & MASK;
        pico::RELATIVE:  m_pc = t ? ((m_pc + sext_imm(i)) & MASK) : ((m_pc + 1) & MASK);
        pico::SUBROUTINE: begin
          if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1;
          end
          m_stack.push_back((m_pc + 1) & MASK);
          m_pc = i & MASK;
        end
        default: begin
          if (m_stack.size() == 0) begin
            m_unf = 1;
            m_pc  = (m_pc + 1) & MASK;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc),    32'(m_pc));
    check({tag, ".sp"},    32'(sp),    32'(m_stack.size()));
    check({tag, ".full"},  32'(full),  32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(m_stack.size() == 0));
    check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    check({tag, ".unf"},   32'(unf),   32'(m_unf));
  endtask

  // Drive one edge's worth of inputs, advance, then compare 1 time unit later
  task automatic step(input string tag, input bit r, input bit e,
                      input pico::modePC m, input bit t, input int i);
    reset = r;
    en    = e;
    mode  = m;
    take  = t;
    imm   = W_IMM'(i);
    @(posedge clk);
    model_edge(r, e, m, t, i);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    mode  = pico::INCREMENT;
    take  = 1'b0;
    imm   = '0;

    step("reset", 1, 0, pico::RETURN, 0, 0);
    check("reset_pc_zero", 32'(pc), 32'h0);

    for (int k = 1; k <= 3; k++) begin
      step("inc", 0, 1, pico::INCREMENT, 0, 0);
      check("inc_pc_lit", 32'(pc), 32'(k));
    end

    step("rst2", 1, 1, pico::INCREMENT, 0, 0);
    step("to_fe", 0, 1, pico::RELATIVE, 1, 'hFE);
    check("rel_neg2", 32'(pc), 32'hFE);
    step("inc_ff", 0, 1, pico::INCREMENT, 0, 0);
    check("inc_ff_lit", 32'(pc), 32'hFF);
    step("wrap", 0, 1, pico::INCREMENT, 0, 0);
    check("wrap_lit", 32'(pc), 32'h00);
    step("to_10", 0, 1, pico::RELATIVE, 1, 'h10);
    step("rel_fc", 0, 1, pico::RELATIVE, 1, 'hFC);
    check("rel_fc_lit", 32'(pc), 32'h0C);
    step("back_10", 0, 1, pico::RELATIVE, 1, 'h04);
    step("rel_nt", 0, 1, pico::RELATIVE, 0, 'hFC);
    check("rel_nt_lit", 32'(pc), 32'h11);

    step("rst3", 1, 1, pico::INCREMENT, 0, 0);
    step("to_05", 0, 1, pico::RELATIVE, 1, 'h05);
    step("call", 0, 1, pico::SUBROUTINE, 0, 'h20);
    check("call_lit", 32'(pc), 32'h20);
    step("ret", 0, 1, pico::RETURN, 0, 0);
    check("ret_lit", 32'(pc), 32'h06);

    step("rst4", 1, 1, pico::INCREMENT, 0, 0);
    for (int k = 1; k <= 5; k++) step("nest", 0, 1, pico::SUBROUTINE, 0, k * 'h10);
    check("nest_ovf_lit", 32'(ovf), 32'h1);
    check("nest_sp_lit", 32'(sp), 32'(DEPTH));
    for (int k = 4; k >= 1; k--) begin
      step("unwind", 0, 1, pico::RETURN, 0, 0);
      check("unwind_lit", 32'(pc), 32'(k * 'h10 + 1));
    end
    step("unwind_unf", 0, 1, pico::RETURN, 0, 0);
    check("unwind_unf_pc", 32'(pc), 32'h12);
    check("unwind_unf_flag", 32'(unf), 32'h1);

    step("rst5", 1, 1, pico::INCREMENT, 0, 0);
    step("pre_stall", 0, 1, pico::SUBROUTINE, 0, 'h33);
    for (int k = 0; k < 5; k++) step("stall", 0, 0, pico::SUBROUTINE, 0, 'h77);
    check("stall_pc_lit", 32'(pc), 32'h33);
    step("resume", 0, 1, pico::SUBROUTINE, 0, 'h44);
    check("resume_sp_lit", 32'(sp), 32'h2);

    for (int k = 0; k < 6; k++) step("fill", 0, 1, pico::SUBROUTINE, 0, 'h50 + k);
    step("pop1", 0, 1, pico::RETURN, 0, 0);
    check("pre_rst_sp", 32'(sp), 32'h3);
    step("rst6", 1, 1, pico::SUBROUTINE, 0, 'h99);
    check("rst6_ovf_lit", 32'(ovf), 32'h0);
    step("ret_after_rst", 0, 1, pico::RETURN, 0, 0);
    check("ret_after_rst_pc", 32'(pc), 32'h1);
    check("ret_after_rst_unf", 32'(unf), 32'h1);

    for (int k = 0; k < 400; k++) begin
      step("rand",
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 85),
           pico::modePC'($urandom_range(0, 3)),
           1'($urandom),
           int'($urandom_range(0, (1 << W_IMM) - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
